// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared FSM state type and frame field sizes for the UART program loader.
package uart_loader_pkg;
  localparam int BYTE_WIDTH = 8;
  localparam int ADDR_BYTES = 4;
  localparam int LEN_BYTES = 2;
  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, WRITE, CHECK} state_t;
endpackage

// File: rtl/uart_loader_shifter.sv
// uart_loader_shifter: little-endian byte-to-word assembly with byte counter and field-complete flag.
module uart_loader_shifter import uart_loader_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [3:0]            target,
  input  logic [BYTE_WIDTH-1:0] din,
  output logic [WIDTH-1:0]      word,
  output logic                  last
);
  logic [WIDTH-1:0] acc;
  logic [3:0] cnt;
  // word already includes the incoming byte so the caller can latch a field on its last byte
  always_comb begin
    word = acc;
    word[cnt*BYTE_WIDTH +: BYTE_WIDTH] = din;
  end
  assign last = en && cnt == target - 4'd1;
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (en) begin
      acc <= word;
      cnt <= last ? 4'd0 : cnt + 4'd1;
    end
  end
endmodule

// File: rtl/uart_loader.sv
// uart_loader: parses sync/address/length/payload frames from a UART FIFO into memory word writes.
// Define UART_LOADER_CHECKSUM_EN to require a trailing zero-sum checksum byte.
module uart_loader import uart_loader_pkg::*; #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 32,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            din,
  input  logic                  empty,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int SW = DATA_WIDTH > 32 ? DATA_WIDTH : 32;
  localparam int WB = DATA_WIDTH / BYTE_WIDTH;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam state_t FIN = CHK ? CHECK : IDLE;
  state_t state, state_d;
  logic pend, cap, timed, field, last, done_d, error_d;
  logic [31:0] tcnt, tcnt_d;
  logic [15:0] n, n_d;
  logic [7:0] sum, sum_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [SW-1:0] word;
  logic [3:0] target;
  // pend marks the cycle the FIFO byte requested last cycle is on din
  assign cap = pend;
  assign timed = state inside {ADDR, LEN, DATA, CHECK};
  assign field = state inside {ADDR, LEN, DATA};
  assign re = rst && !pend && !empty && state != WRITE;
  assign mem_valid = state == WRITE;
  assign busy = state != IDLE;
  assign target = state == ADDR ? 4'(ADDR_BYTES) : state == LEN ? 4'(LEN_BYTES) : 4'(WB);
  uart_loader_shifter #(.WIDTH(SW)) u_shift (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == IDLE),
    .en    (cap && field),
    .target(target),
    .din   (din),
    .word  (word),
    .last  (last)
  );
  always_comb begin
    state_d = state;
    tcnt_d = cap ? 32'd0 : timed ? tcnt + 32'd1 : tcnt;
    n_d = n;
    sum_d = cap && timed ? sum + din : sum;
    addr_d = mem_addr;
    data_d = mem_data;
    done_d = 1'b0;
    error_d = 1'b0;
    if (timed && !cap && tcnt_d == TIMEOUT_CYCLES) begin
      state_d = IDLE;
      error_d = 1'b1;
    end else begin
      case (state)
        IDLE: if (cap && din == SYNC_BYTE) begin
          state_d = ADDR;
          sum_d = 8'd0;
        end
        ADDR: if (last) begin
          addr_d = word[ADDR_WIDTH-1:0];
          state_d = LEN;
        end
        LEN: if (last) begin
          n_d = word[15:0];
          state_d = word[15:0] == 16'd0 ? FIN : DATA;
          done_d = word[15:0] == 16'd0 && !CHK;
        end
        DATA: if (last) begin
          data_d = word[DATA_WIDTH-1:0];
          state_d = WRITE;
        end
        WRITE: if (mem_ready) begin
          addr_d = mem_addr + ADDR_WIDTH'(WB);
          n_d = n - 16'd1;
          state_d = n == 16'd1 ? FIN : DATA;
          done_d = n == 16'd1 && !CHK;
        end
        CHECK: if (cap) begin
          state_d = IDLE;
          done_d = sum_d == 8'd0;
          error_d = sum_d != 8'd0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      pend <= 1'b0;
      tcnt <= '0;
      n <= '0;
      sum <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_d;
      pend <= re;
      tcnt <= tcnt_d;
      n <= n_d;
      sum <= sum_d;
      mem_addr <= addr_d;
      mem_data <= data_d;
      done <= done_d;
      error <= error_d;
    end
  end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: vector table, corner-case sequences and random frames checked against a stream-level model.
module tb_uart_loader;
  localparam int T = 40;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  typedef struct {
    logic [31:0] a;
    int n;
    logic [31:0] w0;
    logic [31:0] w1;
    int junk;
    bit bad;
    int ew;
    logic [63:0] e0;
    logic [63:0] e1;
    bit edone;
  } vec_t;
  logic clk = 0, rst = 0, mem_ready = 1;
  logic empty, re, mem_valid, busy, done, error;
  logic [7:0] din = 0;
  logic [31:0] mem_addr, mem_data;
  logic [7:0] fmem [4096];
  int wp = 0, rp = 0;
  logic [63:0] got_w[$], exp_w[$];
  logic [7:0] frame_q[$];
  logic [31:0] wd [8];
  logic [7:0] csum;
  bit exp_done, re_prev = 0;
  int ncmp = 0, nmis = 0, ndone = 0, nerr = 0, cyc = 0, last_re = 0, err_cyc = 0, rmode = 0;
  vec_t tv [5];

  always #5 clk = ~clk;

  uart_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(32'(T))) dut (
    .clk(clk), .rst(rst), .din(din), .empty(empty), .re(re),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .busy(busy), .done(done), .error(error)
  );

  assign empty = wp == rp;
  always @(posedge clk) if (re) begin
    din <= fmem[rp % 4096];
    rp <= rp + 1;
  end
  always @(posedge clk) if (rst && mem_valid && mem_ready) got_w.push_back({mem_addr, mem_data});
  always @(negedge clk) if (rmode == 1) mem_ready = $urandom_range(0, 2) != 0;

  always @(negedge clk) begin
    cyc++;
    if (re) last_re = cyc;
    if (done) ndone++;
    if (error) begin
      nerr++;
      err_cyc = cyc;
    end
    if (re && (empty || re_prev || mem_valid)) begin
      nmis++;
      $display("FAIL re_protocol: re=1 with empty=%0b prev_re=%0b mem_valid=%0b, required re=0", empty, re_prev, mem_valid);
    end
    if ((done || error) && (busy || (done && error))) begin
      nmis++;
      $display("FAIL pulse: done=%0b error=%0b busy=%0b, required one pulse with busy=0", done, error, busy);
    end
    re_prev = re;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] rj();
    logic [7:0] b = 8'($urandom_range(0, 255));
    return b == 8'hA5 ? 8'h00 : b;
  endfunction

  task automatic put(input logic [7:0] b);
    frame_q.push_back(b);
    csum += b;
  endtask

  task automatic build(input logic [31:0] a, input int n, input int junk, input bit bad);
    logic [7:0] jv [3];
    jv[0] = 8'h00; jv[1] = 8'hFF; jv[2] = 8'h5A;
    frame_q.delete();
    for (int i = 0; i < junk; i++) frame_q.push_back(i < 3 ? jv[i] : rj());
    frame_q.push_back(8'hA5);
    csum = 8'd0;
    for (int k = 0; k < 4; k++) put(a[8*k +: 8]);
    put(8'(n));
    put(8'(n >> 8));
    for (int w = 0; w < n; w++) for (int k = 0; k < 4; k++) put(wd[w][8*k +: 8]);
    if (CK) frame_q.push_back(8'(8'd0 - csum) + 8'(bad));
  endtask

  task automatic model();
    int i = 0, n = 0;
    logic [31:0] a = 0, d;
    logic [7:0] s = 0;
    exp_w.delete();
    while (frame_q[i] != 8'hA5) i++;
    i++;
    for (int k = 0; k < 4; k++) begin a = a | (32'(frame_q[i]) << (8*k)); s += frame_q[i]; i++; end
    for (int k = 0; k < 2; k++) begin n = n | (int'(frame_q[i]) << (8*k)); s += frame_q[i]; i++; end
    for (int w = 0; w < n; w++) begin
      d = 0;
      for (int k = 0; k < 4; k++) begin d = d | (32'(frame_q[i]) << (8*k)); s += frame_q[i]; i++; end
      exp_w.push_back({a, d});
      a += 32'd4;
    end
    if (CK) begin
      s += frame_q[i];
      exp_done = s == 8'd0;
    end else exp_done = 1'b1;
  endtask

  task automatic feed(input int maxgap);
    foreach (frame_q[i]) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      fmem[wp % 4096] = frame_q[i];
      wp++;
    end
  endtask

  task automatic wait_end(input string tag, input int b0, input int b1, output int dd, output int de);
    int t = 0;
    while (!((ndone + nerr) > (b0 + b1) && !busy) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk({tag, " completes"}, 64'(t < 4000), 64'd1);
    chk({tag, " fifo drained"}, 64'(wp == rp), 64'd1);
    dd = ndone - b0;
    de = nerr - b1;
  endtask

  task automatic run_vec(input int i);
    int dd, de, b0, b1;
    string tag = $sformatf("vec%0d", i);
    wd[0] = tv[i].w0;
    wd[1] = tv[i].w1;
    build(tv[i].a, tv[i].n, tv[i].junk, tv[i].bad);
    got_w.delete();
    b0 = ndone;
    b1 = nerr;
    feed(0);
    wait_end(tag, b0, b1, dd, de);
    chk({tag, " writes"}, 64'(got_w.size()), 64'(tv[i].ew));
    for (int j = 0; j < got_w.size() && j < tv[i].ew; j++)
      chk($sformatf("%s wr%0d", tag, j), got_w[j], j == 0 ? tv[i].e0 : tv[i].e1);
    chk({tag, " done"}, 64'(dd), 64'(tv[i].edone));
    chk({tag, " error"}, 64'(de), 64'(!tv[i].edone));
  endtask

  initial begin
    int dd, de, b0, b1, t, nre;
    bit stable;
    logic [31:0] a0, d0;
    tv[0] = '{32'h1000, 2, 32'h44332211, 32'h88776655, 0, 1'b0, 2, {32'h1000, 32'h44332211}, {32'h1004, 32'h88776655}, 1'b1};
    tv[1] = '{32'h1000, 2, 32'h44332211, 32'h88776655, 3, 1'b0, 2, {32'h1000, 32'h44332211}, {32'h1004, 32'h88776655}, 1'b1};
    tv[2] = '{32'hFFFFFFFC, 2, 32'hA5A5A5A5, 32'h01020304, 0, 1'b0, 2, {32'hFFFFFFFC, 32'hA5A5A5A5}, {32'h0, 32'h01020304}, 1'b1};
    tv[3] = '{32'h20, 0, 32'h0, 32'h0, 1, 1'b0, 0, 64'h0, 64'h0, 1'b1};
    tv[4] = '{32'h1000, 2, 32'h44332211, 32'h88776655, 0, 1'b1, 2, {32'h1000, 32'h44332211}, {32'h1004, 32'h88776655}, !CK};

    fmem[0] = 8'h00;
    wp = 1;
    repeat (3) @(negedge clk);
    chk("rst re", 64'(re), 64'd0);
    chk("rst mem_valid", 64'(mem_valid), 64'd0);
    chk("rst mem_addr", 64'(mem_addr), 64'd0);
    chk("rst mem_data", 64'(mem_data), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst error", 64'(error), 64'd0);
    rst = 1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(i);

    wd[0] = 32'h44332211;
    wd[1] = 32'h88776655;
    build(32'h1000, 2, 0, 1'b0);
    got_w.delete();
    b0 = ndone;
    b1 = nerr;
    mem_ready = 0;
    feed(0);
    t = 0;
    while (!mem_valid && t < 200) begin @(negedge clk); t++; end
    chk("bp valid seen", 64'(mem_valid), 64'd1);
    a0 = mem_addr;
    d0 = mem_data;
    stable = 1;
    nre = 0;
    repeat (T + 20) begin
      @(negedge clk);
      if (!mem_valid || mem_addr !== a0 || mem_data !== d0) stable = 0;
      if (re) nre++;
    end
    chk("bp addr", 64'(a0), 64'h1000);
    chk("bp data", 64'(d0), 64'h44332211);
    chk("bp stable", 64'(stable), 64'd1);
    chk("bp no reads", 64'(nre), 64'd0);
    chk("bp no timeout", 64'(nerr - b1), 64'd0);
    mem_ready = 1;
    wait_end("bp", b0, b1, dd, de);
    chk("bp writes", 64'(got_w.size()), 64'd2);
    if (got_w.size() == 2) chk("bp wr1", got_w[1], {32'h1004, 32'h88776655});
    chk("bp done", 64'(dd), 64'd1);

    build(32'h1000, 2, 0, 1'b0);
    while (frame_q.size() > 9) void'(frame_q.pop_back());
    b0 = ndone;
    b1 = nerr;
    feed(0);
    t = 0;
    while (nerr == b1 && t < 500) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    chk("to error", 64'(nerr - b1), 64'd1);
    chk("to latency", 64'(err_cyc - last_re), 64'(T + 2));
    chk("to idle", 64'(busy), 64'd0);
    chk("to no done", 64'(ndone - b0), 64'd0);
    run_vec(0);

    for (int it = 0; it < 25; it++) begin
      string tag = $sformatf("rnd%0d", it);
      int n = $urandom_range(0, 4);
      for (int w = 0; w < n; w++) wd[w] = $urandom;
      build($urandom, n, $urandom_range(0, 4), $urandom_range(0, 3) == 0);
      model();
      got_w.delete();
      b0 = ndone;
      b1 = nerr;
      rmode = 1;
      feed($urandom_range(0, 4));
      wait_end(tag, b0, b1, dd, de);
      rmode = 0;
      @(negedge clk);
      mem_ready = 1;
      chk({tag, " writes"}, 64'(got_w.size()), 64'(exp_w.size()));
      for (int j = 0; j < got_w.size() && j < exp_w.size(); j++)
        chk($sformatf("%s wr%0d", tag, j), got_w[j], exp_w[j]);
      chk({tag, " done"}, 64'(dd), 64'(exp_done));
      chk({tag, " error"}, 64'(de), 64'(!exp_done));
    end

    wd[0] = 32'hDEADBEEF;
    wd[1] = 32'h12345678;
    build(32'hFFFFFFFC, 2, 0, 1'b0);
    if (CK) void'(frame_q.pop_back());
    got_w.delete();
    mem_ready = 0;
    feed(0);
    t = 0;
    while (!mem_valid && t < 200) begin @(negedge clk); t++; end
    chk("wrap first addr", 64'(mem_addr), 64'hFFFFFFFC);
    mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;
    t = 0;
    while (!mem_valid && t < 200) begin @(negedge clk); t++; end
    chk("wrap second addr", 64'(mem_addr), 64'h0);
    chk("wrap second data", 64'(mem_data), 64'h12345678);
    rst = 0;
    @(negedge clk);
    chk("mid rst re", 64'(re), 64'd0);
    chk("mid rst mem_valid", 64'(mem_valid), 64'd0);
    chk("mid rst mem_addr", 64'(mem_addr), 64'd0);
    chk("mid rst mem_data", 64'(mem_data), 64'd0);
    chk("mid rst busy", 64'(busy), 64'd0);
    chk("mid rst done", 64'(done), 64'd0);
    chk("mid rst error", 64'(error), 64'd0);
    chk("mid rst writes", 64'(got_w.size()), 64'd1);
    if (got_w.size() == 1) chk("mid rst wr0", got_w[0], {32'hFFFFFFFC, 32'hDEADBEEF});
    rst = 1;
    mem_ready = 1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end
endmodule
